// File: rtl/quantized_multiplier_gen.sv
// quantized_multiplier_gen: turns three fp32 scales (s_in, s_w, s_out) into the
// (quantized_multiplier, shift) pair consumed by the int32->int8 requantizer.
// The effective scale m = s_in*s_w/s_out is formed with a 24x24 mantissa
// product followed by a 34-cycle serial restoring divider, then normalised to
// a Q0.31 multiplier plus a signed power-of-two shift.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE, and the scale triple is
// captured at the accepting edge. out_valid is high only in DONE. The result
// and flags stay stable until out_ready is seen, and then the block returns
// to IDLE. Upstream must hold its inputs while in_valid is high and
// in_ready is low.
module quantized_multiplier_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] s_in,
    input  logic [31:0] s_w,
    input  logic [31:0] s_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] quantized_multiplier,
    output logic [31:0] shift,
    output logic        err,
    output logic        sat,
    output logic [2:0]  dbg_state
);

    // Quotient bits produced by the divider, one per DIV cycle. Fixed by the
    // operand ranges: (P<<9)/Mo always lies below 2^34.
    localparam int DIV_BITS = 34;
    localparam logic [5:0] DIV_LAST = 6'(DIV_BITS - 1);

    // Legal window for the final shift before clamping.
    localparam logic signed [11:0] SH_MIN = -12'sd31;
    localparam logic signed [11:0] SH_MAX = 12'sd30;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_MUL    = 3'd2,
        S_DIV    = 3'd3,
        S_NORM   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t state_q, state_d;

    // Raw scale triple captured at the accepting edge.
    logic [31:0] sin_q, sin_d;
    logic [31:0] sw_q, sw_d;
    logic [31:0] sout_q, sout_d;

    // Unpacked mantissas (hidden one restored) and biased exponents.
    logic [23:0] mi_q, mi_d;
    logic [23:0] mw_q, mw_d;
    logic [23:0] mo_q, mo_d;
    logic [7:0]  ei_q, ei_d;
    logic [7:0]  ew_q, ew_d;
    logic [7:0]  eo_q, eo_d;

    // Special-case flags decided in UNPACK and carried to NORM.
    logic        bad_q, bad_d;
    logic        zero_q, zero_d;

    // Divider state: partial remainder, unconsumed dividend bits, quotient.
    logic [23:0] rem_q, rem_d;
    logic [33:0] dvd_q, dvd_d;
    logic [33:0] quo_q, quo_d;
    logic [5:0]  cnt_q, cnt_d;

    // Registered outputs, loaded only on entry to DONE.
    logic [31:0] qm_q, qm_d;
    logic [31:0] shift_q, shift_d;
    logic        err_q, err_d;
    logic        sat_q, sat_d;

    // Datapath helpers.
    logic [47:0] prod;
    logic [24:0] rem_sh;
    logic        rem_ge;
    logic [23:0] rem_next;

    // Normalisation results.
    logic [1:0]  nrm_s1;
    logic [30:0] nrm_mant;
    logic        nrm_rb;
    logic [31:0] nrm_rnd;
    logic [2:0]  nrm_s1f;
    logic [31:0] nrm_qv;
    logic [11:0] nrm_sh;
    logic [31:0] nrm_qm;
    logic [31:0] nrm_shift;
    logic        nrm_err;
    logic        nrm_sat;

    // Mantissa product and one restoring-division step (trial subtract).
    always_comb begin
        prod     = {24'd0, mi_q} * {24'd0, mw_q};
        rem_sh   = {rem_q, dvd_q[33]};
        rem_ge   = (rem_sh >= {1'b0, mo_q});
        rem_next = rem_ge ? 24'(rem_sh - {1'b0, mo_q}) : rem_sh[23:0];
    end

    // Normalise the quotient to Q0.31, round, derive the shift and clamp it.
    always_comb begin
        nrm_s1    = 2'd0;
        nrm_mant  = quo_q[31:1];
        nrm_rb    = quo_q[0];
        nrm_rnd   = 32'd0;
        nrm_s1f   = 3'd0;
        nrm_qv    = 32'd0;
        nrm_sh    = 12'd0;
        nrm_qm    = 32'd0;
        nrm_shift = 32'd0;
        nrm_err   = 1'b0;
        nrm_sat   = 1'b0;

        // Leading one sits at bit 31, 32 or 33.
        if (quo_q[33]) begin
            nrm_s1   = 2'd2;
            nrm_mant = quo_q[33:3];
            nrm_rb   = quo_q[2];
        end else if (quo_q[32]) begin
            nrm_s1   = 2'd1;
            nrm_mant = quo_q[32:2];
            nrm_rb   = quo_q[1];
        end

        // Round half up on the most significant dropped bit.
        nrm_rnd = {1'b0, nrm_mant} + {31'd0, nrm_rb};
        if (nrm_rnd == 32'h8000_0000) begin
            // Rounding carried out of Q0.31: renormalise by one position.
            nrm_qv  = 32'h4000_0000;
            nrm_s1f = {1'b0, nrm_s1} + 3'd1;
        end else begin
            nrm_qv  = nrm_rnd;
            nrm_s1f = {1'b0, nrm_s1};
        end

        nrm_sh = {9'd0, nrm_s1f} + {4'd0, ei_q} + {4'd0, ew_q}
               - {4'd0, eo_q} - 12'd127;

        if (bad_q) begin
            nrm_err = 1'b1;
        end else if (zero_q) begin
            nrm_qm = 32'd0;
        end else if ($signed(nrm_sh) < SH_MIN) begin
            // Scale too small to represent: flush to zero.
            nrm_qm = 32'd0;
        end else if ($signed(nrm_sh) > SH_MAX) begin
            nrm_qm    = 32'h7FFF_FFFF;
            nrm_shift = 32'd30;
            nrm_sat   = 1'b1;
        end else begin
            nrm_qm    = nrm_qv;
            nrm_shift = {{20{nrm_sh[11]}}, nrm_sh};
        end
    end

    // Next-state and next-register values for the sequencing FSM.
    always_comb begin
        state_d = state_q;
        sin_d   = sin_q;
        sw_d    = sw_q;
        sout_d  = sout_q;
        mi_d    = mi_q;
        mw_d    = mw_q;
        mo_d    = mo_q;
        ei_d    = ei_q;
        ew_d    = ew_q;
        eo_d    = eo_q;
        bad_d   = bad_q;
        zero_d  = zero_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        qm_d    = qm_q;
        shift_d = shift_q;
        err_d   = err_q;
        sat_d   = sat_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sin_d   = s_in;
                    sw_d    = s_w;
                    sout_d  = s_out;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                mi_d = {1'b1, sin_q[22:0]};
                mw_d = {1'b1, sw_q[22:0]};
                mo_d = {1'b1, sout_q[22:0]};
                ei_d = sin_q[30:23];
                ew_d = sw_q[30:23];
                eo_d = sout_q[30:23];
                // Negative, Inf/NaN, or a zero divisor cannot be encoded.
                bad_d = sin_q[31] | sw_q[31] | sout_q[31]
                      | (&sin_q[30:23]) | (&sw_q[30:23]) | (&sout_q[30:23])
                      | (sout_q[30:23] == 8'd0);
                // Zero/denormal numerator factor gives a zero multiplier.
                zero_d  = (sin_q[30:23] == 8'd0) | (sw_q[30:23] == 8'd0);
                state_d = S_MUL;
            end
            S_MUL: begin
                // Dividend is P<<9. Its top 23 bits are already below Mo,
                // so they seed the remainder and 34 steps remain.
                rem_d   = {1'b0, prod[47:25]};
                dvd_d   = {prod[24:0], 9'd0};
                quo_d   = 34'd0;
                cnt_d   = 6'd0;
                state_d = S_DIV;
            end
            S_DIV: begin
                rem_d = rem_next;
                dvd_d = {dvd_q[32:0], 1'b0};
                quo_d = {quo_q[32:0], rem_ge};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == DIV_LAST) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                qm_d    = nrm_qm;
                shift_d = nrm_shift;
                err_d   = nrm_err;
                sat_d   = nrm_sat;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sin_q   <= 32'd0;
            sw_q    <= 32'd0;
            sout_q  <= 32'd0;
            mi_q    <= 24'd0;
            mw_q    <= 24'd0;
            mo_q    <= 24'd0;
            ei_q    <= 8'd0;
            ew_q    <= 8'd0;
            eo_q    <= 8'd0;
            bad_q   <= 1'b0;
            zero_q  <= 1'b0;
            rem_q   <= 24'd0;
            dvd_q   <= 34'd0;
            quo_q   <= 34'd0;
            cnt_q   <= 6'd0;
            qm_q    <= 32'd0;
            shift_q <= 32'd0;
            err_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sin_q   <= sin_d;
            sw_q    <= sw_d;
            sout_q  <= sout_d;
            mi_q    <= mi_d;
            mw_q    <= mw_d;
            mo_q    <= mo_d;
            ei_q    <= ei_d;
            ew_q    <= ew_d;
            eo_q    <= eo_d;
            bad_q   <= bad_d;
            zero_q  <= zero_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            qm_q    <= qm_d;
            shift_q <= shift_d;
            err_q   <= err_d;
            sat_q   <= sat_d;
        end
    end

    assign in_ready             = (state_q == S_IDLE);
    assign out_valid            = (state_q == S_DONE);
    assign quantized_multiplier = qm_q;
    assign shift                = shift_q;
    assign err                  = err_q;
    assign sat                  = sat_q;
    assign dbg_state            = state_q;

endmodule

// File: doc/quantized_multiplier_gen.md
Name: quantized_multiplier_gen

Overview:
Producer side of the requantization interface. It converts three fp32 quantization scales into the signed 32-bit (quantized_multiplier, shift) pair that the int32->int8 requantizer consumes. The effective scale is m = s_in*s_w/s_out. The block is a multicycle FSM with a serial restoring divider and valid/ready handshakes on both sides. It sits in the per-layer parameter load path ahead of the requantizer.

Parameters:
DIV_BITS, 34, quotient bits produced by the serial divider (one per cycle); fixed, not user-tunable.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low
in_valid  input  1  scale triple valid
in_ready  output  1  high only in IDLE
s_in  input  32  fp32 input scale
s_w  input  32  fp32 weight scale
s_out  input  32  fp32 output scale
out_valid  output  1  result valid, held until accepted
out_ready  input  1  consumer accepts result
quantized_multiplier  output  32  signed Q0.31 multiplier
shift  output  32  signed shift; positive = left shift
err  output  1  invalid input (see below)
sat  output  1  shift clamped high

Behaviour:
- Reset (rst=0 at a clk edge) forces IDLE, in_ready=1, out_valid=0, quantized_multiplier=0, shift=0, err=0, sat=0. Reset mid-operation discards the job.
- States: IDLE -> UNPACK (1 cyc) -> MUL (1 cyc) -> DIV (34 cyc) -> NORM (1 cyc) -> DONE.
- IDLE leaves on in_valid & in_ready. Inputs are latched at that edge T. out_valid rises at T+37 for every input, including special cases.
- DONE holds all outputs stable while out_valid & !out_ready. On handshake the FSM goes to IDLE, and in_ready=1 on the next cycle. The block is never busy and ready at the same time.
- UNPACK: Mx = {1, frac} (24 b); ex = biased exponent.
- Zero handling: s_in or s_w with ex=0 (zero/denormal) gives result q=0, shift=0, err=0.
- err=1 with q=0, shift=0 when any of the following holds:
  - any sign bit is set;
  - any ex=255 (Inf/NaN);
  - s_out has ex=0.
  - err takes priority over the zero case.
- MUL: P = Mi*Mw, 48 b unsigned, P in [2^46, 2^48).
- DIV: Q = floor((P<<9)/Mo), restoring, MSB first, 34 cycles. Q is r in Q2.32, Q in (2^31, 2^34). The division remainder is discarded.
- NORM:
  - p = index of the leading one of Q, p in {31, 32, 33}; s1 = p-31.
  - q = (Q >> (p-30)) + Q[p-31] (round half up on the dropped MSB).
  - If q == 2^31, then q = 2^30 and s1 += 1.
  - sh = s1 + ei + ew - eo - 127, computed in signed 12 b.
  - If sh < -31: q = 0, shift = 0, sat = 0.
  - Else if sh > 30: q = 0x7FFFFFFF, shift = 30, sat = 1.
  - Else: output q, sh.
- Outputs update only on entry to DONE. They hold their last values otherwise, and out_valid=0 except in DONE.
- in_valid while busy is ignored; the upstream must hold the inputs until in_ready.

Test Plan:
- Unit and power-of-two scales:
  - s_in = s_w = s_out = 0x3F800000 -> q = 0x40000000, shift = 1, err = 0, sat = 0; out_valid exactly 37 cycles after accept.
  - s_in = 0x3F000000 (0.5), s_w = 0x3E800000 (0.25), s_out = 1.0 -> q = 0x40000000, shift = -2.
  - s_in = 0x3FC00000 (1.5), others 1.0 -> q = 0x60000000, shift = 1.
- Rounding path: s_in = s_w = 1.0, s_out = 0x40400000 (3.0) -> Q = 0xAAAAAAAA, q = 0x55555555, shift = -1.
- Range clamps:
  - s_in = 0x2B800000 (2^-40), others 1.0 -> q = 0, shift = 0, sat = 0.
  - s_in = 0x53800000 (2^40), others 1.0 -> q = 0x7FFFFFFF, shift = 30, sat = 1.
- Invalid inputs:
  - s_out = 0 -> err = 1, q = 0, shift = 0, latency 37.
  - s_w = 0xBF800000 (negative) -> err = 1.
  - s_in = 0 with valid s_out -> err = 0, q = 0.
- Handshake and reset:
  - Hold out_ready = 0 for 5 cycles after out_valid -> outputs and out_valid stable, in_ready = 0; the handshake cycle returns to IDLE and in_ready = 1 the next cycle.
  - Back-to-back jobs produce correct independent results.
  - rst = 0 during DIV -> next cycle in IDLE with all outputs zero, and no out_valid for the aborted job.
